mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit_if.sv | 46 ++++
 rtl/mc_control_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_unit_if.sv
// Signal bundle between the multicycle control unit and its instruction memory,
// data memory, register file and ALU.
interface mc_control_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ack;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  logic [4:0]      rf_raddr1;
  logic [4:0]      rf_raddr2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  logic [5:0]      alu_func;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;

  modport master (
    output imem_req, imem_addr, input imem_rdata, imem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ack,
    output rf_raddr1, rf_raddr2, input rf_rdata1, rf_rdata2,
    output rf_we, rf_waddr, rf_wdata,
    output alu_func, alu_a, alu_b, input alu_res
  );

  modport slave (
    input imem_req, imem_addr, output imem_rdata, imem_ack,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ack,
    input rf_raddr1, rf_raddr2, output rf_rdata1, rf_rdata2,
    input rf_we, rf_waddr, rf_wdata,
    input alu_func, alu_a, alu_b, output alu_res
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control unit: sequences fetch, decode, execute, memory
// access and write-back over external memories, register file and ALU.
//
// state  | meaning
// FETCH  | imem request held until ack, IR captured
// DECODE | register operands latched, opcode legality checked
// EXEC   | ALU op, address calculation, branch/jump resolution
// MEM    | data memory request held until ack
// WB     | single-cycle register write, pc advance
// ERR    | fault: all requests idle, pc frozen until reset
module mc_control_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h0040_0000),
  parameter int              MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_control_unit_if.master bus,
  output logic [XLEN-1:0]   pc,
  output logic [2:0]        state,
  output logic              err
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_ADDU = 6'd1;
  localparam logic [5:0] ALU_SUB  = 6'd2;
  localparam logic [5:0] ALU_SUBU = 6'd3;
  localparam logic [5:0] ALU_AND  = 6'd4;
  localparam logic [5:0] ALU_OR   = 6'd5;
  localparam logic [5:0] ALU_XOR  = 6'd6;
  localparam logic [5:0] ALU_NOR  = 6'd7;
  localparam logic [5:0] ALU_SLT  = 6'd8;
  localparam logic [5:0] ALU_SLTU = 6'd9;
  localparam logic [5:0] ALU_SLL  = 6'd10;
  localparam logic [5:0] ALU_SRL  = 6'd11;
  localparam logic [5:0] ALU_SRA  = 6'd12;
  localparam logic [5:0] ALU_SLLV = 6'd13;
  localparam logic [5:0] ALU_SRLV = 6'd14;
  localparam logic [5:0] ALU_SRAV = 6'd15;
  localparam logic [5:0] ALU_LUI  = 6'd16;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [31:0]     ir;
  logic [XLEN-1:0] op_a, op_b, res;
  logic [7:0]      wait_cnt;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, waddr;
  logic [15:0] imm16;
  logic [25:0] jaddr;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm16  = ir[15:0];
  assign jaddr  = ir[25:0];

  logic [XLEN-1:0] imm_sext, imm_ext, pc_plus4, br_target, j_target;
  logic is_r, is_shamt, is_jr, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_zext, legal;
  logic [5:0] alu_op;

  assign is_r      = (opcode == 6'h00);
  assign imm_sext  = {{(XLEN-16){imm16[15]}}, imm16};
  assign imm_ext   = is_zext ? {{(XLEN-16){1'b0}}, imm16} : imm_sext;
  assign pc_plus4  = pc + XLEN'(4);
  assign br_target = pc_plus4 + (imm_sext << 2);
  assign j_target  = {pc_plus4[XLEN-1:28], jaddr, 2'b00};

  always_comb begin
    is_shamt = 1'b0;
    is_jr    = 1'b0;
    is_j     = 1'b0;
    is_jal   = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_zext  = 1'b0;
    legal    = 1'b1;
    alu_op   = ALU_ADD;
    if (is_r) begin
      case (funct)
        6'h00: begin alu_op = ALU_SLL; is_shamt = 1'b1; end
        6'h02: begin alu_op = ALU_SRL; is_shamt = 1'b1; end
        6'h03: begin alu_op = ALU_SRA; is_shamt = 1'b1; end
        6'h04: alu_op = ALU_SLLV;
        6'h06: alu_op = ALU_SRLV;
        6'h07: alu_op = ALU_SRAV;
        6'h08: is_jr  = 1'b1;
        6'h20: alu_op = ALU_ADD;
        6'h21: alu_op = ALU_ADDU;
        6'h22: alu_op = ALU_SUB;
        6'h23: alu_op = ALU_SUBU;
        6'h24: alu_op = ALU_AND;
        6'h25: alu_op = ALU_OR;
        6'h26: alu_op = ALU_XOR;
        6'h27: alu_op = ALU_NOR;
        6'h2a: alu_op = ALU_SLT;
        6'h2b: alu_op = ALU_SLTU;
        default: legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'h02: is_j   = 1'b1;
        6'h03: is_jal = 1'b1;
        6'h04: is_beq = 1'b1;
        6'h05: is_bne = 1'b1;
        6'h08: alu_op = ALU_ADD;
        6'h09: alu_op = ALU_ADDU;
        6'h0a: alu_op = ALU_SLT;
        6'h0b: alu_op = ALU_SLTU;
        6'h0c: begin alu_op = ALU_AND; is_zext = 1'b1; end
        6'h0d: begin alu_op = ALU_OR;  is_zext = 1'b1; end
        6'h0e: begin alu_op = ALU_XOR; is_zext = 1'b1; end
        6'h0f: alu_op = ALU_LUI;
        6'h23: is_lw  = 1'b1;
        6'h2b: is_sw  = 1'b1;
        default: legal = 1'b0;
      endcase
    end
  end

  // Requests are gated by rst_n so they drop the instant reset asserts.
  assign waddr          = is_r ? rd : (is_jal ? 5'd31 : rt);
  assign bus.imem_req   = rst_n && (state == S_FETCH);
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = rst_n && (state == S_MEM);
  assign bus.dmem_we    = rst_n && (state == S_MEM) && is_sw;
  assign bus.dmem_addr  = res;
  assign bus.dmem_wdata = op_b;
  assign bus.rf_raddr1  = rs;
  assign bus.rf_raddr2  = rt;
  assign bus.rf_waddr   = waddr;
  assign bus.rf_we      = rst_n && (state == S_WB) && (waddr != 5'd0);
  assign bus.rf_wdata   = res;
  assign bus.alu_func   = alu_op;
  assign bus.alu_a      = is_shamt ? {{(XLEN-5){1'b0}}, shamt} : op_a;
  assign bus.alu_b      = is_r ? op_b : imm_ext;
  assign err            = (state == S_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.imem_ack) begin
            ir    <= bus.imem_rdata;
            state <= S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          op_a  <= bus.rf_rdata1;
          op_b  <= bus.rf_rdata2;
          state <= legal ? S_EXEC : S_ERR;
        end
        S_EXEC: begin
          if (is_lw || is_sw) begin
            res      <= op_a + imm_sext;
            wait_cnt <= '0;
            state    <= S_MEM;
          end else if (is_beq || is_bne) begin
            pc       <= ((op_a == op_b) == is_beq) ? br_target : pc_plus4;
            wait_cnt <= '0;
            state    <= S_FETCH;
          end else if (is_j) begin
            pc       <= j_target;
            wait_cnt <= '0;
            state    <= S_FETCH;
          end else if (is_jr) begin
            pc       <= op_a;
            wait_cnt <= '0;
            state    <= S_FETCH;
          end else if (is_jal) begin
            res   <= pc_plus4;
            state <= S_WB;
          end else begin
            res   <= bus.alu_res;
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            if (is_sw) begin
              pc       <= pc_plus4;
              wait_cnt <= '0;
              state    <= S_FETCH;
            end else begin
              res   <= bus.dmem_rdata;
              state <= S_WB;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          pc       <= is_jal ? j_target : pc_plus4;
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
        default: state <= S_ERR;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: a short program over behavioural memories,
// register file and ALU, with hand-computed results, latencies and fault cases.
module tb_mc_control_unit;
  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        err;

  mc_control_unit_if #(.XLEN(32)) bus ();

  mc_control_unit #(.XLEN(32), .RESET_PC(RPC), .MEM_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .pc    (pc),
    .state (state),
    .err   (err)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [64] = '{default: '0};
  logic [31:0] rf   [32] = '{default: '0};
  logic        imem_hold  = 1'b0;
  int          dmem_delay = 0;
  int          dcnt       = 0;
  logic [31:0] ioff;

  assign ioff           = bus.imem_addr - RPC;
  assign bus.imem_rdata = imem[ioff[7:2]];
  assign bus.imem_ack   = bus.imem_req && !imem_hold;
  assign bus.dmem_rdata = 32'hDEAD_BEEF;
  assign bus.dmem_ack   = bus.dmem_req && (dcnt == dmem_delay);
  assign bus.rf_rdata1  = (bus.rf_raddr1 == 5'd0) ? 32'd0 : rf[bus.rf_raddr1];
  assign bus.rf_rdata2  = (bus.rf_raddr2 == 5'd0) ? 32'd0 : rf[bus.rf_raddr2];

  // Behavioural ALU: ADD ADDU SUB SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV LUI = 0..16
  always_comb begin
    case (bus.alu_func)
      6'd0, 6'd1:         bus.alu_res = bus.alu_a + bus.alu_b;
      6'd2, 6'd3:         bus.alu_res = bus.alu_a - bus.alu_b;
      6'd4:               bus.alu_res = bus.alu_a & bus.alu_b;
      6'd5:               bus.alu_res = bus.alu_a | bus.alu_b;
      6'd6:               bus.alu_res = bus.alu_a ^ bus.alu_b;
      6'd7:               bus.alu_res = ~(bus.alu_a | bus.alu_b);
      6'd8:               bus.alu_res = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      6'd9:               bus.alu_res = {31'd0, bus.alu_a < bus.alu_b};
      6'd10, 6'd13:       bus.alu_res = bus.alu_b << bus.alu_a[4:0];
      6'd11, 6'd14:       bus.alu_res = bus.alu_b >> bus.alu_a[4:0];
      6'd12, 6'd15:       bus.alu_res = $signed(bus.alu_b) >>> bus.alu_a[4:0];
      6'd16:              bus.alu_res = bus.alu_b << 16;
      default:            bus.alu_res = 32'd0;
    endcase
  end

  int          we_cnt = 0, dreq_tot = 0, daddr_chg = 0, st_cnt = 0;
  logic [4:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0, daddr_last = '0, st_addr = '0, st_data = '0;

  always @(posedge clk) begin
    dcnt <= bus.dmem_req ? dcnt + 1 : 0;
    if (bus.rf_we) begin
      rf[bus.rf_waddr] <= bus.rf_wdata;
      last_waddr       <= bus.rf_waddr;
      last_wdata       <= bus.rf_wdata;
      we_cnt           <= we_cnt + 1;
    end
    if (bus.dmem_req) begin
      if (dcnt != 0 && bus.dmem_addr != daddr_last) daddr_chg <= daddr_chg + 1;
      daddr_last <= bus.dmem_addr;
      dreq_tot   <= dreq_tot + 1;
      if (bus.dmem_ack && bus.dmem_we) begin
        st_addr <= bus.dmem_addr;
        st_data <= bus.dmem_wdata;
        st_cnt  <= st_cnt + 1;
      end
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] addr);
    return {op, addr};
  endfunction

  // Starts at a falling edge in FETCH; returns cycles until FETCH again and the
  // cycle (1-based) in which rf_we was seen, 0 if never. Bounded at 40 cycles.
  task automatic run_instr(output int cyc, output int we_cyc);
    cyc    = 0;
    we_cyc = 0;
    do begin
      if (bus.rf_we) we_cyc = cyc + 1;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (state != 3'd0 && cyc < 40);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cyc, wc, we0, dr0, ch0;
    imem[0]  = enc_i(6'h09, 5'd0, 5'd1, 16'd5);
    imem[1]  = enc_i(6'h0d, 5'd0, 5'd3, 16'h8000);
    imem[2]  = enc_i(6'h09, 5'd0, 5'd4, 16'hFFFF);
    imem[3]  = enc_r(5'd1, 5'd4, 5'd5, 5'd0, 6'h21);
    imem[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    imem[5]  = enc_r(5'd0, 5'd1, 5'd6, 5'd3, 6'h00);
    imem[6]  = enc_i(6'h09, 5'd0, 5'd1, 16'h0100);
    imem[7]  = enc_i(6'h23, 5'd1, 5'd2, 16'd4);
    imem[8]  = enc_i(6'h2b, 5'd1, 5'd2, 16'd8);
    imem[9]  = enc_r(5'd1, 5'd1, 5'd0, 5'd0, 6'h21);
    imem[10] = enc_j(6'h02, 26'h010000B);
    imem[11] = enc_j(6'h03, 26'h0100000);
    imem[12] = 32'hFC00_0000;

    #12;
    chk("rst_state", state, 3'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_err", err, 1'b0);
    chk("rst_imem_req", bus.imem_req, 1'b0);
    chk("rst_dmem_req", bus.dmem_req, 1'b0);
    chk("rst_rf_we", bus.rf_we, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(cyc, wc);
    chk("addiu_cycles", cyc, 4);
    chk("addiu_we_cycle", wc, 4);
    chk("addiu_waddr", last_waddr, 5'd1);
    chk("addiu_wdata", last_wdata, 32'd5);
    chk("addiu_pc", pc, RPC + 32'd4);

    run_instr(cyc, wc);
    chk("ori_zext_wdata", last_wdata, 32'h0000_8000);
    chk("ori_waddr", last_waddr, 5'd3);

    run_instr(cyc, wc);
    chk("addiu_sext_wdata", last_wdata, 32'hFFFF_FFFF);

    run_instr(cyc, wc);
    chk("addu_wrap_wdata", last_wdata, 32'd4);
    chk("addu_rd", last_waddr, 5'd5);

    we0 = we_cnt;
    run_instr(cyc, wc);
    chk("beq_cycles", cyc, 3);
    chk("beq_pc", pc, 32'h0040_0010);
    chk("beq_no_we", we_cnt - we0, 0);

    imem[4] = enc_i(6'h05, 5'd1, 5'd1, 16'hFFFF);
    run_instr(cyc, wc);
    chk("bne_cycles", cyc, 3);
    chk("bne_pc", pc, 32'h0040_0014);

    run_instr(cyc, wc);
    chk("sll_wdata", last_wdata, 32'h28);
    chk("sll_waddr", last_waddr, 5'd6);

    run_instr(cyc, wc);
    chk("addiu_base_wdata", last_wdata, 32'h100);

    dmem_delay = 3;
    dr0 = dreq_tot;
    ch0 = daddr_chg;
    run_instr(cyc, wc);
    chk("lw_cycles", cyc, 8);
    chk("lw_req_cycles", dreq_tot - dr0, 4);
    chk("lw_addr", daddr_last, 32'h104);
    chk("lw_addr_stable", daddr_chg - ch0, 0);
    chk("lw_waddr", last_waddr, 5'd2);
    chk("lw_wdata", last_wdata, 32'hDEAD_BEEF);

    dmem_delay = 0;
    we0 = we_cnt;
    run_instr(cyc, wc);
    chk("sw_cycles", cyc, 4);
    chk("sw_stores", st_cnt, 1);
    chk("sw_addr", st_addr, 32'h108);
    chk("sw_data", st_data, 32'hDEAD_BEEF);
    chk("sw_no_we", we_cnt - we0, 0);
    chk("sw_pc", pc, 32'h0040_0024);

    we0 = we_cnt;
    run_instr(cyc, wc);
    chk("r0_cycles", cyc, 4);
    chk("r0_write_suppressed", we_cnt - we0, 0);

    run_instr(cyc, wc);
    chk("j_cycles", cyc, 3);
    chk("j_pc", pc, 32'h0040_002C);

    run_instr(cyc, wc);
    chk("jal_cycles", cyc, 4);
    chk("jal_waddr", last_waddr, 5'd31);
    chk("jal_wdata", last_wdata, 32'h0040_0030);
    chk("jal_pc", pc, RPC);

    imem[0] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    run_instr(cyc, wc);
    chk("jr_cycles", cyc, 3);
    chk("jr_pc", pc, 32'h0040_0030);

    we0 = we_cnt;
    dr0 = dreq_tot;
    step(2);
    chk("illegal_state", state, 3'd7);
    chk("illegal_err", err, 1'b1);
    step(3);
    chk("err_pc_frozen", pc, 32'h0040_0030);
    chk("err_imem_req", bus.imem_req, 1'b0);
    chk("illegal_no_we", we_cnt - we0, 0);
    chk("illegal_no_dreq", dreq_tot - dr0, 0);

    rst_n = 1'b0;
    #1;
    chk("rst2_state", state, 3'd0);
    chk("rst2_err", err, 1'b0);
    imem_hold = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(15);
    chk("fetch_wait_15", state, 3'd0);
    step(1);
    chk("fetch_timeout_state", state, 3'd7);
    chk("fetch_timeout_err", err, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst3_state", state, 3'd0);
    chk("rst3_err", err, 1'b0);
    chk("rst3_pc", pc, RPC);

    imem_hold  = 1'b0;
    imem[0]    = enc_i(6'h23, 5'd0, 5'd2, 16'd4);
    dmem_delay = 10;
    @(negedge clk);
    rst_n = 1'b1;
    we0 = we_cnt;
    step(3);
    chk("midmem_state", state, 3'd3);
    chk("midmem_req", bus.dmem_req, 1'b1);
    chk("midmem_addr", bus.dmem_addr, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("midmem_req_drop", bus.dmem_req, 1'b0);
    chk("midmem_state_rst", state, 3'd0);
    step(2);
    chk("midmem_no_we", we_cnt - we0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
